// File: rtl/audio_adc_capture.sv
// rtl/audio_adc_capture.sv - WM8731 I2S ADC deframer with show-ahead stereo pair FIFO
//
// Purpose: synchronises the codec I2S pins into the clk domain, deframes
// DATA_WIDTH-bit left/right words after the one-bit I2S delay, and queues
// complete pairs in a FIFO_DEPTH-entry show-ahead FIFO.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   bclk, adc_lrck,     raw codec pins, asynchronous to clk
//   adc_dat
//   sample_left/right   FIFO head words, zero while empty
//   sample_valid        FIFO not empty
//   sample_ready        consumer takes the head when valid & ready
//   fifo_level          pairs currently held
//   overflow            sticky, complete pair dropped on a full FIFO
//   frame_error         sticky, slot ended before DATA_WIDTH bits arrived
//   clear_errors        synchronous clear of both sticky flags (set wins)
module audio_adc_capture #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          bclk,
  input  logic                          adc_lrck,
  input  logic                          adc_dat,
  output logic [DATA_WIDTH-1:0]         sample_left,
  output logic [DATA_WIDTH-1:0]         sample_right,
  output logic                          sample_valid,
  input  logic                          sample_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          frame_error,
  input  logic                          clear_errors
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [4:0] K_FULL = 5'(DATA_WIDTH);
  localparam logic [4:0] K_MAX  = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LEFT  = 2'd1,
    ST_RIGHT = 2'd2
  } state_t;

  // ---------------------------------------------------------------------
  // Pin synchronisers. lrck and data use the same two-flop depth as bclk
  // so that at rise_evt they show the values present at the bclk rise.
  // ---------------------------------------------------------------------
  logic [1:0] bclk_sync;
  logic [1:0] lrck_sync;
  logic [1:0] dat_sync;
  logic       bclk_hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bclk_sync <= '0;
      lrck_sync <= '0;
      dat_sync  <= '0;
      bclk_hist <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk};
      lrck_sync <= {lrck_sync[0], adc_lrck};
      dat_sync  <= {dat_sync[0], adc_dat};
      bclk_hist <= bclk_sync[1];
    end
  end

  logic rise_evt;
  logic lr;
  logic din;

  assign rise_evt = bclk_sync[1] & ~bclk_hist;
  assign lr       = lrck_sync[1];
  assign din      = dat_sync[1];

  // ---------------------------------------------------------------------
  // Deframer
  // ---------------------------------------------------------------------
  state_t                state;
  logic                  lr_prev;
  logic [4:0]            k;
  logic                  left_ok;
  logic [DATA_WIDTH-1:0] left_sh;
  logic [DATA_WIDTH-1:0] right_sh;

  logic       lr_edge;
  logic [4:0] k_next;
  logic       slot_complete;
  logic       capture_bit;
  logic       push;
  logic       ferr_set;

  assign lr_edge       = rise_evt & (lr != lr_prev);
  assign k_next        = (k == K_MAX) ? k : k + 5'd1;
  // k holds the index of the last bit of the slot that is now ending.
  assign slot_complete = (k >= K_FULL);
  assign capture_bit   = rise_evt & ~lr_edge & (k_next <= K_FULL);

  assign push = lr_edge & (state == ST_RIGHT) & ~lr & slot_complete & left_ok;

  assign ferr_set = lr_edge &
                    (((state == ST_LEFT)  &  lr & ~slot_complete) |
                     ((state == ST_RIGHT) & ~lr & ~(slot_complete & left_ok)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      lr_prev     <= 1'b0;
      k           <= '0;
      left_ok     <= 1'b0;
      left_sh     <= '0;
      right_sh    <= '0;
      frame_error <= 1'b0;
    end else begin
      if (rise_evt) begin
        lr_prev <= lr;
        k       <= lr_edge ? 5'd0 : k_next;
      end

      if (capture_bit) begin
        if (lr) right_sh <= (right_sh << 1) | DATA_WIDTH'(din);
        else    left_sh  <= (left_sh << 1) | DATA_WIDTH'(din);
      end

      if (lr_edge) begin
        case (state)
          ST_IDLE: begin
            if (!lr) state <= ST_LEFT;
          end
          ST_LEFT: begin
            if (lr) begin
              left_ok <= slot_complete;
              state   <= ST_RIGHT;
            end
          end
          ST_RIGHT: begin
            if (!lr) begin
              left_ok <= 1'b0;
              state   <= ST_LEFT;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end

      if (ferr_set)          frame_error <= 1'b1;
      else if (clear_errors) frame_error <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Show-ahead pair FIFO
  // ---------------------------------------------------------------------
  logic [2*DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;
  logic                    full;
  logic                    pop;
  logic                    wr_en;
  logic [2*DATA_WIDTH-1:0] head;

  assign full  = (level == LW'(FIFO_DEPTH));
  assign pop   = sample_valid & sample_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= {left_sh, right_sh};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({wr_en, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase

      if (push & full & ~pop) overflow <= 1'b1;
      else if (clear_errors)  overflow <= 1'b0;
    end
  end

  assign head         = mem[rd_ptr];
  assign sample_valid = (level != '0);
  assign fifo_level   = level;

  always_comb begin
    sample_left  = '0;
    sample_right = '0;
    if (sample_valid) begin
      sample_left  = head[2*DATA_WIDTH-1:DATA_WIDTH];
      sample_right = head[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_audio_adc_capture.sv
// tb/tb_audio_adc_capture.sv - directed scoreboard bench for audio_adc_capture
module tb_audio_adc_capture;

  localparam int DW = 24;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          bclk;
  logic          adc_lrck;
  logic          adc_dat;
  logic [DW-1:0] sample_left;
  logic [DW-1:0] sample_right;
  logic          sample_valid;
  logic          sample_ready;
  logic [2:0]    fifo_level;
  logic          overflow;
  logic          frame_error;
  logic          clear_errors;

  always #10 clk = ~clk;

  audio_adc_capture #(.DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .clk          (clk),
    .reset        (reset),
    .bclk         (bclk),
    .adc_lrck     (adc_lrck),
    .adc_dat      (adc_dat),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .frame_error  (frame_error),
    .clear_errors (clear_errors)
  );

  int errors = 0;
  int checks = 0;
  int pops   = 0;
  int base;

  logic [2*DW-1:0] exp_q[$];
  logic [2*DW-1:0] mon_e;
  logic            aligned;
  logic            exp_ovf;
  logic            exp_ferr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Consumer side of the scoreboard: every accepted head is compared with
  // the oldest pair the stimulus expects to have been queued.
  always @(negedge clk) begin
    if (reset === 1'b0 && sample_valid === 1'b1 && sample_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_pop observed=%h_%h expected=none", sample_left, sample_right);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pop_left",  32'(sample_left),  32'(mon_e[2*DW-1:DW]));
        chk("pop_right", 32'(sample_right), 32'(mon_e[DW-1:0]));
      end
      pops++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One bclk period of 8 clk; lrck/dat settle 4 clk before the rise and
  // hold 4 clk after. With pulse set, ready is high exactly across the
  // clock edge on which the DUT writes for this rise.
  task automatic drive_bit(input logic lr, input logic d, input bit pulse);
    bclk     = 1'b0;
    adc_lrck = lr;
    adc_dat  = d;
    repeat (4) tick();
    bclk = 1'b1;
    if (pulse) begin
      tick();
      tick();
      sample_ready = 1'b1;
      tick();
      sample_ready = 1'b0;
      tick();
    end else begin
      repeat (4) tick();
    end
  endtask

  task automatic sb_push(input logic [DW-1:0] l, input logic [DW-1:0] r, input bit coinc);
    if (exp_q.size() < FD || coinc) exp_q.push_back({l, r});
    else exp_ovf = 1'b1;
  endtask

  // Left data bits (after a delay bit already sent), right slot, then the
  // 1->0 delay bit that opens the next left slot and completes this frame.
  task automatic send_frame(input logic [DW-1:0] l, input logic [DW-1:0] r,
                            input int rbits, input logic extra, input bit pulse);
    int nr;
    for (int i = 1; i <= 31; i++) drive_bit(1'b0, (i <= DW) ? l[DW-i] : extra, 1'b0);
    drive_bit(1'b1, 1'b0, 1'b0);
    nr = (rbits >= DW) ? 31 : rbits;
    for (int i = 1; i <= nr; i++) drive_bit(1'b1, (i <= DW) ? r[DW-i] : extra, 1'b0);
    if (aligned) begin
      if (rbits >= DW) sb_push(l, r, pulse);
      else exp_ferr = 1'b1;
    end
    drive_bit(1'b0, 1'b0, pulse);
    aligned = 1'b1;
  endtask

  task automatic wait_pops(input string tag, input int target);
    int budget = 400;
    while (pops < target && budget > 0) begin
      tick();
      budget--;
    end
    repeat (4) tick();
    chk(tag, 32'(pops), 32'(target));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_left"},  32'(sample_left),  32'h0);
    chk({tag, "_right"}, 32'(sample_right), 32'h0);
    chk({tag, "_valid"}, 32'(sample_valid), 32'h0);
    chk({tag, "_level"}, 32'(fifo_level),   32'h0);
    chk({tag, "_ovf"},   32'(overflow),     32'h0);
    chk({tag, "_ferr"},  32'(frame_error),  32'h0);
  endtask

  initial begin
    reset        = 1'b1;
    bclk         = 1'b0;
    adc_lrck     = 1'b0;
    adc_dat      = 1'b0;
    sample_ready = 1'b0;
    clear_errors = 1'b0;
    aligned      = 1'b0;
    exp_ovf      = 1'b0;
    exp_ferr     = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1: three frames after reset, first one absorbed by alignment
    sample_ready = 1'b1;
    base = pops;
    for (int f = 0; f < 3; f++) send_frame(24'hA5A5A5, 24'h5A5A5A, DW, 1'b0, 1'b0);
    wait_pops("t1_pops", base + 2);
    chk("t1_ferr", 32'(frame_error), 32'(exp_ferr));
    chk("t1_valid", 32'(sample_valid), 32'h0);

    // 2: overflow with consumer stalled
    sample_ready = 1'b0;
    for (int f = 0; f < 6; f++)
      send_frame(24'h111111 * (f + 1), ~(24'h111111 * (f + 1)), DW, 1'b0, 1'b0);
    repeat (4) tick();
    chk("t2_level", 32'(fifo_level), 32'd4);
    chk("t2_ovf", 32'(overflow), 32'(exp_ovf));
    chk("t2_head", 32'(sample_left), 32'(exp_q[0][2*DW-1:DW]));
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    exp_ovf = 1'b0;
    chk("t2_ovf_clr", 32'(overflow), 32'(exp_ovf));
    base = pops;
    sample_ready = 1'b1;
    wait_pops("t2_drain", base + 4);
    chk("t2_empty", 32'(fifo_level), 32'd0);

    // 3: short right slot
    sample_ready = 1'b0;
    send_frame(24'h123456, 24'h654321, DW, 1'b0, 1'b0);
    send_frame(24'hDEAD00, 24'h00BEEF, 10, 1'b0, 1'b0);
    repeat (4) tick();
    chk("t3_ferr", 32'(frame_error), 32'(exp_ferr));
    chk("t3_level", 32'(fifo_level), 32'd1);
    send_frame(24'hC0FFEE, 24'h0BADF0, DW, 1'b0, 1'b0);
    repeat (4) tick();
    chk("t3_level2", 32'(fifo_level), 32'd2);
    base = pops;
    sample_ready = 1'b1;
    wait_pops("t3_drain", base + 2);
    clear_errors = 1'b1;
    tick();
    clear_errors = 1'b0;
    exp_ferr = 1'b0;
    chk("t3_ferr_clr", 32'(frame_error), 32'(exp_ferr));

    // 4: push and pop in the same cycle on a full FIFO
    sample_ready = 1'b0;
    for (int f = 0; f < 4; f++)
      send_frame(24'h400000 + 24'(f), 24'h0A0000 + 24'(f), DW, 1'b0, 1'b0);
    repeat (4) tick();
    chk("t4_full", 32'(fifo_level), 32'd4);
    base = pops;
    send_frame(24'h4F4F4F, 24'hF4F4F4, DW, 1'b0, 1'b1);
    repeat (4) tick();
    chk("t4_level", 32'(fifo_level), 32'd4);
    chk("t4_ovf", 32'(overflow), 32'(exp_ovf));
    chk("t4_onepop", 32'(pops), 32'(base + 1));
    sample_ready = 1'b1;
    wait_pops("t4_drain", base + 5);

    // 5: asynchronous reset in the middle of a left slot
    sample_ready = 1'b0;
    send_frame(24'h777777, 24'h888888, DW, 1'b0, 1'b0);
    for (int i = 1; i <= 5; i++) drive_bit(1'b0, 1'b1, 1'b0);
    chk("t5_pre_valid", 32'(sample_valid), 32'h1);
    #3;
    reset = 1'b1;
    #1;
    chk_all_zero("t5_reset");
    exp_q.delete();
    aligned  = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    sample_ready = 1'b1;
    base = pops;
    send_frame(24'h999999, 24'hAAAAAA, DW, 1'b0, 1'b0);
    send_frame(24'hBBBBBB, 24'hCCCCCC, DW, 1'b0, 1'b0);
    wait_pops("t5_pops", base + 1);

    // 6: bits beyond DATA_WIDTH ignored
    base = pops;
    send_frame(24'h000001, 24'h800000, DW, 1'b1, 1'b0);
    wait_pops("t6_pops", base + 1);
    chk("end_ferr", 32'(frame_error), 32'(exp_ferr));
    chk("end_ovf", 32'(overflow), 32'(exp_ovf));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_adc_capture.md
# audio_adc_capture

Receives the WM8731 ADC I2S stream (BCLK, ADCLRCK, ADCDAT) in the 50 MHz system domain and deframes it into 24-bit left/right sample pairs. It pushes each pair into a small show-ahead FIFO with a valid/ready output, isolating downstream DSP and bus logic from codec timing. It sits directly downstream of the codec pins and their serial deserialisation, and upstream of the audio processing path.

## Interface
- DATA_WIDTH, 24, bits per channel word captured after the I2S delay bit (1..30)
- FIFO_DEPTH, 4, stereo pairs buffered; power of two, ≥2
- clk  in  1  system clock, 50 MHz; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- bclk  in  1  codec bit clock, asynchronous to clk
- adc_lrck  in  1  codec L/R clock, asynchronous; 0 = left slot, 1 = right slot
- adc_dat  in  1  codec serial data, MSB first
- sample_left  out  DATA_WIDTH  FIFO head, left word; 0 when FIFO empty
- sample_right  out  DATA_WIDTH  FIFO head, right word; 0 when FIFO empty
- sample_valid  out  1  FIFO not empty
- sample_ready  in  1  consumer accepts head when valid & ready
- fifo_level  out  clog2(FIFO_DEPTH)+1  pairs currently held
- overflow  out  1  sticky: a complete pair was dropped because the FIFO was full
- frame_error  out  1  sticky: a slot ended before DATA_WIDTH bits were captured
- clear_errors  in  1  synchronous clear of overflow and frame_error

## Operation
- bclk, adc_lrck, adc_dat each pass through a 2-flop synchroniser plus one history flop. rise_evt = synced bclk 1 and history 0.
- All deframing acts only in rise_evt cycles. lr_prev holds adc_lrck sampled at the previous rise_evt.
- Slot index k: the rise_evt where adc_lrck ≠ lr_prev has k=0 (I2S delay bit, ignored). Each following rise_evt increments k, saturating at 31. Bits at k=1..DATA_WIDTH shift MSB-first into the current channel register. Bits at k>DATA_WIDTH are ignored. A slot is complete when k reached DATA_WIDTH.
- FSM states:
  - IDLE: waits for a transition 1→0, then goes to LEFT.
  - LEFT: on a transition 0→1, latches left_ok = complete; if not complete, sets frame_error. Goes to RIGHT.
  - RIGHT: on a transition 1→0, if the right slot is also complete and left_ok is set, pushes {left, right}. Otherwise sets frame_error and drops the pair. Goes to LEFT.
- The first partial frame after reset is never pushed and never flags frame_error, because IDLE does not capture.
- FIFO behaviour:
  - Push when full with no pop in the same cycle: pair discarded, overflow set, contents unchanged.
  - Push when full with a pop in the same cycle: pair accepted, level unchanged.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- Sticky flags: when clear_errors coincides with a set event, set wins.
- Reset value of every output is 0:
  - sample_left, sample_right, sample_valid, fifo_level, overflow, frame_error are all 0.
  - State returns to IDLE and the FIFO empties.
  - Asserting reset mid-frame discards any partial pair; capture resumes at the next 1→0 transition.

## Timing
- Pin bclk rise to rise_evt: 2–3 clk cycles. adc_lrck and adc_dat see the same delay, so they are sampled coherently.
- Requirement: bclk high and low phases are each ≥3 clk cycles. adc_lrck and adc_dat are stable ≥3 clk cycles around each bclk rise.
- FIFO write occurs on the clock edge ending the rise_evt cycle that detects the 1→0 transition. sample_valid, head data and fifo_level update the following cycle.
- Pop takes effect on the edge where valid & ready. The next head, or zeros plus valid=0, appears the following cycle.
- Flags assert in the cycle after the causing event. Full-throughput operation sustains one pair per LRCK frame.

## Test plan
- Reset, then 3 I2S frames (bclk = clk/8, 32 bclk per slot): L=0xA5A5A5, R=0x5A5A5A, ready=1. Required: exactly 2 pairs popped, because frame 1 is consumed by IDLE alignment. Both pairs have the exact values; frame_error=0.
- ready=0, 6 complete frames: fifo_level saturates at 4. The first 4 pairs are retained in order. overflow=1 after the 5th pair. clear_errors → overflow=0 next cycle.
- Short right slot (LRCK toggles after 10 bits): frame_error=1, no push, level unchanged. The next normal frame is pushed correctly.
- FIFO full, with pop and push in the same cycle: level stays 4, overflow stays 0. The popped pair is the oldest and the new pair becomes the tail.
- Reset asserted asynchronously mid-left-slot: all outputs 0 immediately. With 2 following frames, only the second is pushed.
- Extra data bits at k=25..31 set to 1, with L=0x000001: captured left = 0x000001, so the extra bits are ignored.
